// File: rtl/bp_be_mul_pkg.sv
// Shared op encoding and helpers for the BE multiply pipe.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bp_be_mul_pkg;

    localparam int mul_op_width_gp = 3;

    typedef enum logic [mul_op_width_gp-1:0] {
        e_mul_op_mul    = 3'd0,
        e_mul_op_mulh   = 3'd1,
        e_mul_op_mulhsu = 3'd2,
        e_mul_op_mulhu  = 3'd3,
        e_mul_op_mulw   = 3'd4
    } bp_be_mul_op_e;

    // Reserved encodings, and MULW on a build without word support, fold to MUL.
    function automatic bp_be_mul_op_e bp_be_mul_op_legalize(
        input logic [mul_op_width_gp-1:0] op,
        input logic                       word_en
    );
        case (op)
            3'd1:    return e_mul_op_mulh;
            3'd2:    return e_mul_op_mulhsu;
            3'd3:    return e_mul_op_mulhu;
            3'd4:    return word_en ? e_mul_op_mulw : e_mul_op_mul;
            default: return e_mul_op_mul;
        endcase
    endfunction

endpackage

// File: rtl/bp_be_mul_stage.sv
// One pipeline slice of the multiply pipe: a valid bit plus an opaque payload.
// Latency: 1 cycle. kill_i masks the held valid combinationally, so a killed op
// Backpressure: none; the slice advances every cycle and never stalls.
module bp_be_mul_stage #(
    parameter int data_width_p = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    kill_i,
    input  logic                    v_i,
    input  logic [data_width_p-1:0] data_i,
    output logic                    v_o,
    output logic [data_width_p-1:0] data_o
);

    logic                    v_q;
    logic [data_width_p-1:0] data_q;

    // Valid bit: cleared asynchronously so in-flight ops vanish on reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) v_q <= 1'b0;
        else         v_q <= v_i;
    end

    // Payload: no reset needed, only captured when an op enters the slice.
    always_ff @(posedge clk_i) begin
        if (v_i) data_q <= data_i;
    end

    assign v_o    = v_q & ~kill_i;
    assign data_o = data_q;

endmodule

// File: rtl/bp_be_pipe_mul_pipelined.sv
// Fully pipelined RV64M integer multiplier for the BE execute pipe.
// Latency: latency_p cycles issue-to-result, one op accepted per cycle.
// Backpressure: none; EX1/EX2 kills squash ops in stages 1 and 2 only.
module bp_be_pipe_mul_pipelined
    import bp_be_mul_pkg::*;
#(
    parameter int width_p   = 64,
    parameter int latency_p = 4,
    parameter bit word_en_p = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    input  logic [mul_op_width_gp-1:0] op_i,
    input  logic [width_p-1:0]         rs1_i,
    input  logic [width_p-1:0]         rs2_i,
    input  logic                       kill_ex1_i,
    input  logic                       kill_ex2_i,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o
);

    localparam int prod_width_lp = 2*width_p + 2;
    // Number of partial-product stages; latency 2 does the whole multiply in stage 2.
    localparam int num_pp_lp     = (latency_p > 2) ? latency_p - 2 : 1;
    // Low chunks of rs2 are chunk_lp bits; the top chunk absorbs the remainder and the sign bit.
    localparam int chunk_lp      = (width_p + 1) / num_pp_lp;
    localparam bit mulw_en_lp    = word_en_p && (width_p == 64);
    localparam int word_lp       = (width_p < 32) ? width_p : 32;

    typedef struct packed {
        bp_be_mul_op_e              op;
        logic [width_p:0]           a;
        logic [width_p:0]           b;
        logic [prod_width_lp-1:0]   acc;
    } payload_s;

    localparam int payload_width_lp = $bits(payload_s);

    // Adds a * (rs2 bits selected by mask) into the running product. Low
    // 2w+2 bits of a two's complement product do not depend on signedness,
    // so both factors are sign-extended and multiplied unsigned.
    function automatic payload_s mul_step(input payload_s p, input logic [width_p:0] mask);
        logic [width_p:0]         part;
        logic [prod_width_lp-1:0] a_ext;
        logic [prod_width_lp-1:0] b_ext;
        payload_s                 r;
        part  = p.b & mask;
        a_ext = {{(width_p+1){p.a[width_p]}}, p.a};
        b_ext = {{(width_p+1){part[width_p]}}, part};
        r     = p;
        r.acc = p.acc + a_ext * b_ext;
        return r;
    endfunction

    logic     stage_v_li    [1:latency_p];
    logic     stage_v_lo    [1:latency_p];
    payload_s stage_data_li [1:latency_p];
    payload_s stage_data_lo [1:latency_p];

    bp_be_mul_op_e    op_legal;
    logic [width_p:0] a_prep;
    logic [width_p:0] b_prep;

    // Operand prep: extend to width_p+1 with the signedness the op calls for.
    always_comb begin
        op_legal = bp_be_mul_op_legalize(op_i, mulw_en_lp);
        a_prep   = {1'b0, rs1_i};
        b_prep   = {1'b0, rs2_i};
        case (op_legal)
            e_mul_op_mulh: begin
                a_prep = {rs1_i[width_p-1], rs1_i};
                b_prep = {rs2_i[width_p-1], rs2_i};
            end
            e_mul_op_mulhsu: begin
                a_prep = {rs1_i[width_p-1], rs1_i};
            end
            e_mul_op_mulw: begin
                a_prep                = {(width_p+1){rs1_i[word_lp-1]}};
                a_prep[word_lp-1:0]   = rs1_i[word_lp-1:0];
                b_prep                = {(width_p+1){rs2_i[word_lp-1]}};
                b_prep[word_lp-1:0]   = rs2_i[word_lp-1:0];
            end
            default: ;
        endcase
    end

    assign stage_v_li[1]    = v_i;
    assign stage_data_li[1] = '{op: op_legal, a: a_prep, b: b_prep, acc: '0};

    for (genvar s = 1; s <= latency_p; s++) begin : stage
        bp_be_mul_stage #(
            .data_width_p(payload_width_lp)
        ) slice (
            .clk_i  (clk_i),
            .reset_i(reset_i),
            .kill_i ((s == 1) ? kill_ex1_i : ((s == 2) ? kill_ex2_i : 1'b0)),
            .v_i    (stage_v_li[s]),
            .data_i (stage_data_li[s]),
            .v_o    (stage_v_lo[s]),
            .data_o (stage_data_lo[s])
        );
    end

    for (genvar s = 2; s <= latency_p; s++) begin : link
        localparam int k_lp = s - 2;
        assign stage_v_li[s] = stage_v_lo[s-1];
        if (k_lp < num_pp_lp) begin : mul
            localparam logic [width_p:0] mask_lp = (k_lp == num_pp_lp - 1)
                ? ({(width_p+1){1'b1}} << (k_lp*chunk_lp))
                : (((width_p+1)'(1) << chunk_lp) - (width_p+1)'(1)) << (k_lp*chunk_lp);
            assign stage_data_li[s] = mul_step(stage_data_lo[s-1], mask_lp);
        end else begin : pass
            assign stage_data_li[s] = stage_data_lo[s-1];
        end
    end

    payload_s         fin;
    logic             fin_v;
    logic [width_p-1:0] result;
    logic             unused_fin;

    assign fin        = stage_data_lo[latency_p];
    assign fin_v      = stage_v_lo[latency_p];
    assign unused_fin = ^{fin.a, fin.b, fin.acc[prod_width_lp-1:2*width_p]};

    // Result select on the finished product.
    always_comb begin
        result = fin.acc[width_p-1:0];
        case (fin.op)
            e_mul_op_mulh, e_mul_op_mulhsu, e_mul_op_mulhu: begin
                result = fin.acc[2*width_p-1:width_p];
            end
            e_mul_op_mulw: begin
                result                = {width_p{fin.acc[word_lp-1]}};
                result[word_lp-1:0]   = fin.acc[word_lp-1:0];
            end
            default: ;
        endcase
    end

    assign v_o    = fin_v;
    assign data_o = result & {width_p{fin_v}};

endmodule
